// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Bit positions of the classic control fields inside the ctrl vector.
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEM2REG  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_BRZERO   = 4;

  // Default widths for an ID/EX-sized boundary.
  localparam int DATA_W_DEF = 64;
  localparam int CTRL_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// One valid/ready channel carrying a data and a control payload.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  // Producer side of the channel.
  modport master (output valid, output data, output ctrl, input ready);
  // Consumer side of the channel.
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready, flush-to-bubble, optional
// two-entry skid buffer and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  pipe_stage_reg_if.slave  in_if,
  pipe_stage_reg_if.master out_if,
  output logic [CNT_W-1:0] stall_cnt_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              in_ready;
  logic              out_valid;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_if.valid & in_ready;
  assign out_fire  = out_valid & out_if.ready;

  // Next state and main-entry load; flush wins over any transfer.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d     = ST_FULL;
          main_data_d = in_if.data;
          main_ctrl_d = in_if.ctrl;
        end
      end
      ST_FULL: begin
        if (in_fire && out_fire) begin
          main_data_d = in_if.data;
          main_ctrl_d = in_if.ctrl;
        end else if (in_fire) begin
          state_d = ST_SKID;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_fire) begin
          state_d     = ST_FULL;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d     = ST_EMPTY;
      main_data_d = main_data_q;
    end
    // Bubbles carry zero control so downstream enables stay quiet.
    if (state_d == ST_EMPTY) main_ctrl_d = '0;
  end

  // Main entry and state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic in_rdy_q;
      logic skid_load;

      // Capture into skid when main is held and a new input arrives.
      assign skid_load = (state_q == ST_FULL) & in_fire & ~out_fire & ~flush_i;

      // Skid entry plus registered ready, so ready never sees out_ready.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          in_rdy_q    <= 1'b1;
          skid_data_q <= '0;
          skid_ctrl_q <= '0;
        end else begin
          in_rdy_q <= (state_d != ST_SKID);
          if (skid_load) begin
            skid_data_q <= in_if.data;
            skid_ctrl_q <= in_if.ctrl;
          end
        end
      end

      assign in_ready = in_rdy_q;
    end else begin : g_noskid
      assign skid_data_q = '0;
      assign skid_ctrl_q = '0;
      assign in_ready    = ~out_valid | out_if.ready;
    end
  endgenerate

  // Saturating count of cycles where output is held back; flush keeps it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_if.ready && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_data_q;
  assign out_if.ctrl  = main_ctrl_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboarded checks for pipe_stage_reg, SKID=1 and SKID=0.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_fl, b_fl;
  logic [15:0] a_stall, b_stall;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
  } ent_t;
  ent_t qa[$];
  ent_t qb[$];

  pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(8)) a_in ();
  pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(8)) a_out ();
  pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(8)) b_in ();
  pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(8)) b_out ();

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1'b1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_fl),
    .in_if(a_in), .out_if(a_out), .stall_cnt_o(a_stall)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1'b0), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_fl),
    .in_if(b_in), .out_if(b_out), .stall_cnt_o(b_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called with inputs settled, just before the edge that acts on them.
  task automatic sb_cycle();
    ent_t e;
    if (a_out.valid && a_out.ready) begin
      if (qa.size() == 0) chk("a_sb_underflow", 64'd1, 64'd0);
      else begin
        e = qa.pop_front();
        chk("a_sb_data", a_out.data, e.d);
        chk("a_sb_ctrl", {56'd0, a_out.ctrl}, {56'd0, e.c});
      end
    end
    if (!a_out.valid) chk("a_bubble_ctrl", {56'd0, a_out.ctrl}, 64'd0);
    if (a_fl) qa.delete();
    else if (a_in.valid && a_in.ready) begin
      e.d = a_in.data; e.c = a_in.ctrl; qa.push_back(e);
    end
    if (b_out.valid && b_out.ready) begin
      if (qb.size() == 0) chk("b_sb_underflow", 64'd1, 64'd0);
      else begin
        e = qb.pop_front();
        chk("b_sb_data", b_out.data, e.d);
        chk("b_sb_ctrl", {56'd0, b_out.ctrl}, {56'd0, e.c});
      end
    end
    if (!b_out.valid) chk("b_bubble_ctrl", {56'd0, b_out.ctrl}, 64'd0);
    if (b_in.valid && b_in.ready) begin
      e.d = b_in.data; e.c = b_in.ctrl; qb.push_back(e);
    end
  endtask

  initial begin
    a_in.valid = 1'b0; a_in.data = '0; a_in.ctrl = '0; a_out.ready = 1'b0; a_fl = 1'b0;
    b_in.valid = 1'b0; b_in.data = '0; b_in.ctrl = '0; b_out.ready = 1'b0; b_fl = 1'b0;

    // Reset held for three cycles
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", a_out.valid, 1'b0);
    chk("rst_data", a_out.data, 64'd0);
    chk("rst_ctrl", a_out.ctrl, 8'd0);
    chk("rst_in_ready", a_in.ready, 1'b1);
    chk("rst_stall", a_stall, 16'd0);
    chk("rst_b_in_ready", b_in.ready, 1'b1);
    rst_n = 1'b1;

    // Stream 1..8 with downstream always ready
    a_out.ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      a_in.valid = 1'b1; a_in.data = 64'(k); a_in.ctrl = 8'(k);
      tick();
      chk("stream_valid", a_out.valid, 1'b1);
      chk("stream_data", a_out.data, 64'(k));
      chk("stream_ctrl", a_out.ctrl, 8'(k));
    end
    a_in.valid = 1'b0;
    tick();
    chk("stream_end_valid", a_out.valid, 1'b0);
    chk("stream_end_ctrl", a_out.ctrl, 8'd0);
    chk("stream_end_hold", a_out.data, 64'd8);

    // Bubble forces control to zero
    a_in.valid = 1'b1; a_in.data = 64'h55; a_in.ctrl = 8'h1F;
    tick();
    chk("bubble_ctrl_on", a_out.ctrl, 8'h1F);
    a_in.valid = 1'b0;
    tick();
    chk("bubble_ctrl_off", a_out.ctrl, 8'h00);
    chk("bubble_valid", a_out.valid, 1'b0);
    chk("bubble_data_hold", a_out.data, 64'h55);

    // Backpressure fills main then skid
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 64'hA; a_in.ctrl = 8'h03;
    tick();
    chk("bp_a_data", a_out.data, 64'hA);
    chk("bp_a_ready", a_in.ready, 1'b1);
    chk("bp_a_stall", a_stall, 16'd0);
    a_in.data = 64'hB; a_in.ctrl = 8'h04;
    tick();
    chk("bp_b_data", a_out.data, 64'hA);
    chk("bp_b_ready", a_in.ready, 1'b0);
    chk("bp_b_stall", a_stall, 16'd1);
    a_in.data = 64'hC; a_in.ctrl = 8'h05;
    tick();
    chk("bp_c_held_data", a_out.data, 64'hA);
    chk("bp_c_held_ready", a_in.ready, 1'b0);
    chk("bp_c_stall", a_stall, 16'd2);
    a_out.ready = 1'b1;
    tick();
    chk("drain_b_data", a_out.data, 64'hB);
    chk("drain_b_ctrl", a_out.ctrl, 8'h04);
    chk("drain_b_ready", a_in.ready, 1'b1);
    chk("drain_b_stall", a_stall, 16'd2);
    tick();
    chk("drain_c_data", a_out.data, 64'hC);
    chk("drain_c_ctrl", a_out.ctrl, 8'h05);
    a_in.valid = 1'b0;
    tick();
    chk("drain_empty", a_out.valid, 1'b0);

    // Flush from the skid state with a pending input
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 64'hA; a_in.ctrl = 8'h03;
    tick();
    a_in.data = 64'hB; a_in.ctrl = 8'h04;
    tick();
    chk("fl_pre_ready", a_in.ready, 1'b0);
    a_fl = 1'b1; a_in.data = 64'hD; a_in.ctrl = 8'h07;
    tick();
    chk("fl_valid", a_out.valid, 1'b0);
    chk("fl_ctrl", a_out.ctrl, 8'h00);
    chk("fl_ready", a_in.ready, 1'b1);
    chk("fl_stall", a_stall, 16'd4);
    a_fl = 1'b0; a_in.valid = 1'b0; a_out.ready = 1'b1;
    tick();
    chk("fl_no_d", a_out.valid, 1'b0);

    // Flush from full with simultaneous accept and consume
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 64'hE; a_in.ctrl = 8'h09;
    tick();
    chk("fl2_full_data", a_out.data, 64'hE);
    a_fl = 1'b1; a_in.data = 64'hF; a_out.ready = 1'b1;
    tick();
    chk("fl2_valid", a_out.valid, 1'b0);
    chk("fl2_stall", a_stall, 16'd4);
    a_fl = 1'b0; a_in.valid = 1'b0;
    tick();
    chk("fl2_no_f", a_out.valid, 1'b0);
    chk("fl2_data_hold", a_out.data, 64'hE);

    // Random traffic on both variants against scoreboards
    for (int c = 0; c < 4000; c++) begin
      a_in.valid = 1'($urandom_range(0, 1));
      a_in.data = {$urandom, $urandom}; a_in.ctrl = 8'($urandom);
      a_out.ready = ($urandom_range(0, 3) != 0);
      a_fl = ($urandom_range(0, 49) == 0);
      b_in.valid = 1'($urandom_range(0, 1));
      b_in.data = {$urandom, $urandom}; b_in.ctrl = 8'($urandom);
      b_out.ready = ($urandom_range(0, 3) != 0);
      #1;
      sb_cycle();
      tick();
    end
    a_in.valid = 1'b0; a_fl = 1'b0; a_out.ready = 1'b1;
    b_in.valid = 1'b0; b_out.ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      sb_cycle();
      tick();
    end
    chk("a_sb_empty", 64'(qa.size()), 64'd0);
    chk("b_sb_empty", 64'(qb.size()), 64'd0);

    // SKID=0: ready drops with full stage and rises with out_ready same cycle
    b_out.ready = 1'b0;
    b_in.valid = 1'b1; b_in.data = 64'h11; b_in.ctrl = 8'h01;
    #1;
    chk("b_empty_ready", b_in.ready, 1'b1);
    tick();
    b_in.valid = 1'b0;
    #1;
    chk("b_full_valid", b_out.valid, 1'b1);
    chk("b_full_data", b_out.data, 64'h11);
    chk("b_full_ready", b_in.ready, 1'b0);
    b_out.ready = 1'b1;
    #1;
    chk("b_comb_ready", b_in.ready, 1'b1);
    tick();
    chk("b_drained", b_out.valid, 1'b0);

    // Asynchronous reset mid-operation
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 64'h77; a_in.ctrl = 8'h02;
    tick();
    a_in.valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", a_out.valid, 1'b0);
    chk("arst_data", a_out.data, 64'd0);
    chk("arst_ctrl", a_out.ctrl, 8'd0);
    chk("arst_ready", a_in.ready, 1'b1);
    chk("arst_stall", a_stall, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Stall counter counts exactly, then saturates and survives flush
    a_in.valid = 1'b1; a_in.data = 64'h99; a_in.ctrl = 8'h01;
    tick();
    a_in.valid = 1'b0;
    repeat (100) tick();
    chk("cnt_100", a_stall, 16'd100);
    repeat (69900) tick();
    chk("cnt_sat", a_stall, 16'hFFFF);
    tick();
    chk("cnt_no_wrap", a_stall, 16'hFFFF);
    chk("cnt_held_data", a_out.data, 64'h99);
    a_fl = 1'b1;
    tick();
    a_fl = 1'b0;
    chk("cnt_flush_valid", a_out.valid, 1'b0);
    chk("cnt_flush_keep", a_stall, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
